// File: rtl/phase_chk_pkg.sv
// Shared definitions for the two-phase pattern checker.
//   state_t  : checker FSM states (HUNT, VERIFY, LOCKED)
//   SYM_A/B  : the two legal symbols, written as {in1,in2}
//   exp_sym  : expected symbol for a given phase of the 4-cycle pattern
package phase_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] SYM_A = 2'b10;
    localparam logic [1:0] SYM_B = 2'b01;

    // Phases 0 and 1 carry A, phases 2 and 3 carry B, so phase[1] selects.
    function automatic logic [1:0] exp_sym(input logic [1:0] ph);
        return ph[1] ? SYM_B : SYM_A;
    endfunction

endpackage

// File: rtl/phase_pattern_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   inc      : count up by one (holds at all-ones)
//   clr      : zero the count; takes priority over inc
//   cnt      : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != {W{1'b1}})) begin
            cnt_reg <= cnt_reg + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/phase_pattern_checker.sv
// Receive-side checker for the repeating {in1,in2} pattern 10,10,01,01.
// Hunts for the 10->01 transition, verifies LOCK_CYCLES further samples,
// then free-runs a phase flywheel and reports symbol errors.
//   clk, rst  : clock and synchronous active-high reset
//   in1, in2  : pattern bits, sampled directly on each rising edge
//   clr_err   : synchronous clear of err_cnt
//   locked    : high while locked
//   phase     : phase of the most recently accepted sample (valid when locked)
//   err_pulse : one-cycle strobe per mismatched sample while locked
//   err_cnt   : saturating count of locked-state mismatches
module phase_pattern_checker
    import phase_chk_pkg::*;
#(
    parameter int LOCK_CYCLES = 8,
    parameter int LOSS_THRESH = 3,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1,
    input  logic             in2,
    input  logic             clr_err,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MC_W = $clog2(LOCK_CYCLES + 1);
    localparam int MS_W = $clog2(LOSS_THRESH + 1);

    localparam logic [MC_W-1:0] MC_ONE    = MC_W'(1);
    localparam logic [MC_W-1:0] MC_TARGET = MC_W'(LOCK_CYCLES);
    localparam logic [MS_W-1:0] MS_ONE    = MS_W'(1);
    localparam logic [MS_W-1:0] MS_TARGET = MS_W'(LOSS_THRESH);

    state_t          state_reg, state_next;
    logic [1:0]      phase_reg, phase_next;
    logic [MC_W-1:0] match_cnt_reg, match_cnt_next;
    logic [MS_W-1:0] miss_cnt_reg, miss_cnt_next;
    logic [1:0]      prev_reg;
    logic            locked_reg, locked_next;
    logic            err_pulse_reg, err_pulse_next;
    logic            err_inc;

    logic [1:0] cur_sym;
    logic [1:0] phase_adv;
    logic       sym_ok;

    assign cur_sym   = {in1, in2};
    assign phase_adv = phase_reg + 2'd1;
    // Both VERIFY and LOCKED judge the incoming sample against the phase
    // that follows the last accepted one.
    assign sym_ok    = (cur_sym == exp_sym(phase_adv));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HUNT;
            phase_reg     <= 2'd0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            prev_reg      <= 2'b00;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            prev_reg      <= cur_sym;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        locked_next    = locked_reg;
        err_pulse_next = 1'b0;
        err_inc        = 1'b0;

        case (state_reg)
            HUNT: begin
                // The A->B edge marks the sample just taken as phase 2.
                if ((prev_reg == SYM_A) && (cur_sym == SYM_B)) begin
                    state_next     = VERIFY;
                    phase_next     = 2'd2;
                    match_cnt_next = '0;
                end
            end

            VERIFY: begin
                if (sym_ok) begin
                    phase_next     = phase_adv;
                    match_cnt_next = match_cnt_reg + MC_ONE;
                    if ((match_cnt_reg + MC_ONE) == MC_TARGET) begin
                        state_next    = LOCKED;
                        locked_next   = 1'b1;
                        miss_cnt_next = '0;
                    end
                end else begin
                    // Failed verification is not an error; just start over.
                    state_next     = HUNT;
                    match_cnt_next = '0;
                end
            end

            LOCKED: begin
                // Flywheel keeps running through bad samples.
                phase_next = phase_adv;
                if (sym_ok) begin
                    miss_cnt_next = '0;
                end else begin
                    err_pulse_next = 1'b1;
                    err_inc        = 1'b1;
                    miss_cnt_next  = miss_cnt_reg + MS_ONE;
                    if ((miss_cnt_reg + MS_ONE) == MS_TARGET) begin
                        state_next  = HUNT;
                        locked_next = 1'b0;
                    end
                end
            end

            default: begin
                state_next  = HUNT;
                locked_next = 1'b0;
            end
        endcase
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .clr (clr_err),
        .cnt (err_cnt)
    );

    assign locked    = locked_reg;
    assign phase     = phase_reg;
    assign err_pulse = err_pulse_reg;

endmodule

// File: tb/tb_phase_pattern_checker.sv
module tb_phase_pattern_checker;

    localparam int LOCK_CYCLES = 8;
    localparam int LOSS_THRESH = 3;
    localparam int ERR_W       = 4;
    localparam int ERR_MAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in1 = 1'b0;
    logic             in2 = 1'b0;
    logic             clr_err = 1'b0;
    logic             locked;
    logic [1:0]       phase;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    always #5 clk = ~clk;

    phase_pattern_checker #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .LOSS_THRESH (LOSS_THRESH),
        .ERR_W       (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .clr_err   (clr_err),
        .locked    (locked),
        .phase     (phase),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int         cyc;
        logic       locked;
        logic       chk_phase;
        logic [1:0] phase;
        logic       err_pulse;
        logic [3:0] err_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input int cyc, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // Monitor: every rising edge, check any expectations targeted at it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc_cnt++;
            #1;
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e = exp_q.pop_front();
                if (e.cyc != cyc_cnt) begin
                    cmp("sched", cyc_cnt, e.cyc, cyc_cnt);
                end else begin
                    cmp("locked", e.cyc, int'(locked), int'(e.locked));
                    cmp("err_pulse", e.cyc, int'(err_pulse), int'(e.err_pulse));
                    cmp("err_cnt", e.cyc, int'(err_cnt), int'(e.err_cnt));
                    if (e.chk_phase)
                        cmp("phase", e.cyc, int'(phase), int'(e.phase));
                    $display("cyc %0d rst=%0b in=%0b%0b clr=%0b -> locked=%0b phase=%0d pulse=%0b err=%0d",
                             e.cyc, rst, in1, in2, clr_err, locked, phase, err_pulse, err_cnt);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Tracked in terms of "which pattern position was last accepted" and
    // plain integer counters.
    bit         m_hunting = 1;
    bit         m_locked  = 0;
    int         m_pos     = 0;   // running pattern position, phase = pos % 4
    int         m_matches = 0;
    int         m_misses  = 0;
    int         m_errs    = 0;
    bit         m_pulse   = 0;
    logic [1:0] m_prev    = 2'b00;

    function automatic logic [1:0] pattern_sym(input int pos);
        return ((pos % 4) < 2) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_step(input logic [1:0] cur, input logic clr, input logic r);
        bit good;
        m_pulse = 0;
        if (r) begin
            m_hunting = 1; m_locked = 0; m_pos = 0;
            m_matches = 0; m_misses = 0; m_errs = 0; m_prev = 2'b00;
            return;
        end
        good = (cur == pattern_sym(m_pos + 1));
        if (m_locked) begin
            m_pos = (m_pos + 1) % 4;
            if (good) m_misses = 0;
            else begin
                m_pulse = 1;
                if (m_errs < ERR_MAX) m_errs = m_errs + 1;
                m_misses = m_misses + 1;
                if (m_misses == LOSS_THRESH) begin
                    m_locked = 0; m_hunting = 1;
                end
            end
        end else if (m_hunting) begin
            if (m_prev == 2'b10 && cur == 2'b01) begin
                m_hunting = 0; m_pos = 2; m_matches = 0;
            end
        end else begin
            if (good) begin
                m_pos = (m_pos + 1) % 4;
                m_matches = m_matches + 1;
                if (m_matches == LOCK_CYCLES) begin
                    m_locked = 1; m_misses = 0;
                end
            end else begin
                m_hunting = 1; m_matches = 0;
            end
        end
        if (clr) m_errs = 0;
        m_prev = cur;
    endtask

    // ---------------- stimulus ----------------
    int gen_pos = 0;

    task automatic drive(input logic [1:0] sym, input logic clr, input logic r);
        exp_t e;
        @(negedge clk);
        {in1, in2} = sym;
        clr_err    = clr;
        rst        = r;
        model_step(sym, clr, r);
        e.cyc       = cyc_cnt + 1;
        e.locked    = m_locked;
        e.chk_phase = r || !m_hunting;
        e.phase     = 2'(m_pos % 4);
        e.err_pulse = m_pulse;
        e.err_cnt   = 4'(m_errs);
        exp_q.push_back(e);
    endtask

    task automatic gen(input int n);
        for (int i = 0; i < n; i++) begin
            drive(pattern_sym(gen_pos), 1'b0, 1'b0);
            gen_pos++;
        end
    endtask

    // Replace the generator's symbol for one cycle with a corrupt one.
    task automatic corrupt(input logic [1:0] sym, input logic clr);
        drive(sym, clr, 1'b0);
        gen_pos++;
    endtask

    task automatic do_reset();
        drive(2'b10, 1'b0, 1'b1);
        gen_pos = 0;
    endtask

    initial begin
        int r;
        logic [1:0] bad;

        // Reset and clean lock, long error-free run.
        do_reset();
        do_reset();
        gen(120);

        // Single illegal 11 while locked.
        corrupt(2'b11, 1'b0);
        gen(20);

        // Three consecutive 00 drop lock, then relock.
        for (int i = 0; i < 3; i++) corrupt(2'b00, 1'b0);
        gen(40);

        // Saturation: one isolated bad sample per 8-cycle window.
        for (int i = 0; i < 20; i++) begin
            gen(7);
            corrupt((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
        end
        gen(3);
        corrupt(2'b11, 1'b1);   // clear coinciding with counted error
        gen(10);

        // Phase slip during VERIFY at match 5, then relock.
        do_reset();
        gen(7);
        drive(2'b10, 1'b0, 1'b0);   // extra A, generator does not advance
        gen(40);

        // Build err_cnt to 5 while locked, then reset and reacquire.
        for (int i = 0; i < 5; i++) begin
            gen(5);
            corrupt(2'b00, 1'b0);
        end
        gen(2);
        do_reset();
        gen(30);

        // Randomised corruption, slips, clears and occasional resets.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            bad = 2'($urandom_range(0, 3));
            if (r < 6)       corrupt(bad, 1'($urandom_range(0, 1)));
            else if (r < 9)  drive(bad, 1'b0, 1'b0);          // slip
            else if (r < 11) begin
                drive(pattern_sym(gen_pos), 1'b1, 1'b0);
                gen_pos++;
            end
            else if (r == 11) do_reset();
            else             gen(1);
        end
        gen(2);

        @(posedge clk);
        #3;
        cmp("queue_drained", cyc_cnt, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/phase_pattern_checker.md
Name: phase_pattern_checker

Overview:
- Receive-side companion to the two-phase pattern generator in the Ethernet test area.
- Monitors the generator's pair of 1-bit outputs, which repeat `10,10,01,01` (shown as `{in1,in2}`) with a 4-cycle period.
- Locks onto the phase, then free-runs a phase flywheel and flags, counts and reports symbol errors.
- Used as a self-checking sink in bring-up and test fabrics ahead of the MAC.

Parameters:
- `LOCK_CYCLES`, 8: consecutive matching samples after the first detection needed to declare lock (≥1).
- `LOSS_THRESH`, 3: consecutive mismatches while LOCKED that drop lock (≥1).
- `ERR_W`, 8: width of the saturating error counter (≥2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in1`  in  1  pattern bit A; high in phases 0 and 1.
- `in2`  in  1  pattern bit B; high in phases 2 and 3.
- `clr_err`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  high while in the LOCKED state.
- `phase`  out  2  phase index of the most recently accepted sample; meaningful only when `locked` is high.
- `err_pulse`  out  1  one-cycle strobe per mismatched sample while LOCKED.
- `err_cnt`  out  `ERR_W`  saturating count of LOCKED-state mismatches.

Behaviour:
- Inputs are sampled directly at each `posedge clk`. All outputs are registered and update on the edge that samples the deciding input, so latency is 0 cycles after the sampling edge.
- Symbols: `A = 10`, `B = 01`. `00` and `11` are illegal and always count as a mismatch.
- Expected symbol for phase p: A when p is 0 or 1, B when p is 2 or 3.
- `prev` register holds the previous sample. It is updated every cycle in every state and cleared to `00` by reset.
- Reset values: state HUNT, `locked` 0, `phase` 0, `err_pulse` 0, `err_cnt` 0, `match_cnt` 0, `miss_cnt` 0, `prev` 00.
- HUNT:
  - When `prev == A` and current sample `== B`: set `phase` to 2, clear `match_cnt`, go to VERIFY.
  - Anything else: stay in HUNT.
- VERIFY (`locked` = 0):
  - Expected symbol is that of `phase+1` (mod 4).
  - On a match: `phase` increments, `match_cnt` increments. If the new count equals `LOCK_CYCLES`, go to LOCKED, assert `locked` on the same edge, and clear `miss_cnt`.
  - On a mismatch: go to HUNT and clear `match_cnt`. No error is counted. The 10→01 check in HUNT starts from the next cycle.
- LOCKED:
  - The phase flywheel always advances by 1 per cycle, whether the sample matches or not.
  - On a match: clear `miss_cnt`.
  - On a mismatch: pulse `err_pulse` for one cycle, increment `err_cnt` (saturating at 2^`ERR_W`−1), and increment `miss_cnt`.
  - When `miss_cnt` reaches `LOSS_THRESH`: go to HUNT and deassert `locked` on that same edge. That mismatch is still counted.
- `clr_err`:
  - Zeroes `err_cnt` on the next edge in any state.
  - If it coincides with a counted mismatch, the clear wins: `err_cnt` becomes 0, and `err_pulse` still asserts.
- Reset mid-operation: everything returns to reset values on the next edge. Lock must be fully reacquired.
- Counting: `err_cnt` holds at its maximum value with no wrap. `phase` wraps 3→0.

Decomposition:
- Package `phase_chk_pkg`:
  - state enum {HUNT, VERIFY, LOCKED};
  - symbol constants `SYM_A` = 2'b10 and `SYM_B` = 2'b01;
  - function `exp_sym(phase)` returning the expected symbol for a phase.
- Sub-module `sat_counter` (parameter `W`; ports `inc`, `clr` with clear priority, `cnt`) implements `err_cnt`.
- FSM, flywheel and `miss_cnt` live in the top module.

Test Plan (samples numbered s1, s2, … from the first clock after `rst` deasserts):
- Generator connected, `LOCK_CYCLES`=8: s1=10, s2=10, s3=01 triggers detection (`phase`=2) → `locked` rises on the edge sampling s11. `phase` then cycles 3,0,1,2,…, `err_cnt` stays 0 for 100 cycles.
- Locked, force `{in1,in2}`=11 for one cycle → `err_pulse` high for exactly 1 cycle, `err_cnt`=1, `locked` stays 1, and the next correct samples match with no further errors.
- Locked, force 00 for 3 consecutive cycles (`LOSS_THRESH`=3) → `err_cnt`=3, `locked` falls on the 3rd bad edge. After release, relock is reached 8 matches after the next 10→01.
- `ERR_W`=4, inject one isolated bad sample per 8-cycle window, 20 times → `err_cnt` saturates at 15, `locked` stays 1. Assert `clr_err` in the same cycle as an injected error → `err_cnt`=0 and `err_pulse`=1.
- Insert an extra `10` during VERIFY (phase slip at match 5) → returns to HUNT with no error counted, and locks 8 matches after the next 10→01.
- Assert `rst` for one cycle while locked with `err_cnt`=5 → next edge shows `locked`=0, `err_cnt`=0, `phase`=0, and lock is reacquired per scenario 1.
